// File: rtl/aes_key_scheduler.sv
// Iterative AES-128/192/256 key expansion: one schedule word per cycle from an NK-word window,
// round keys streamed out in order over a valid/ready handshake.
module aes_key_scheduler #(
   parameter int KEY_BITS = 128
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [KEY_BITS-1:0] key_in,
   output logic                busy,
   output logic                rk_valid,
   input  logic                rk_ready,
   output logic [127:0]        rk_data,
   output logic [3:0]          rk_round
);
   localparam int NK = KEY_BITS / 32;
   localparam int NR = NK + 6;
   localparam int NW = 4 * (NR + 1);
   localparam logic [5:0] NK_I   = 6'(NK);
   localparam logic [5:0] LAST_I = 6'(NW - 1);
   localparam logic [2:0] LAST_J = 3'(NK - 1);
   localparam logic [3:0] LAST_R = 4'(NR);

   generate
      if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
         $error("aes_key_scheduler: KEY_BITS must be 128, 192 or 256");
      end
   endgenerate

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box: multiplicative inverse as a^254 (0 maps to 0), then the affine transform.
   function automatic logic [7:0] aes_box(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int k = 1; k < 8; k++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   typedef enum logic [1:0] {S_IDLE, S_GEN, S_DRAIN} state_t;

   state_t        state_q, state_d;
   logic [5:0]    i_q, i_d;
   logic [2:0]    j_q, j_d;
   logic [7:0]    rcon_q, rcon_d;
   logic [31:0]   win_q [NK];
   logic [95:0]   asm_q;
   logic          rk_valid_q;
   logic [127:0]  rk_data_q;
   logic [3:0]    rk_round_q;

   logic          load, advance, accept;
   logic [31:0]   prev, old, sb_in, sb_out, temp, word;

   assign load    = (state_q == S_IDLE) && start;
   assign advance = (state_q == S_GEN) && (!rk_valid_q || rk_ready);
   assign accept  = rk_valid_q && rk_ready;
   assign prev    = win_q[NK-1];
   assign old     = win_q[0];

   always_comb begin
      sb_in  = (j_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
      sb_out = {aes_box(sb_in[31:24]), aes_box(sb_in[23:16]),
                aes_box(sb_in[15:8]),  aes_box(sb_in[7:0])};
      temp = prev;
      if (j_q == 3'd0) temp = sb_out ^ {rcon_q, 24'h0};
      else if (NK == 8 && j_q == 3'd4) temp = sb_out;
      // While i < NK the window still holds the raw key; rotating it emits the key words.
      word = (i_q < NK_I) ? old : (old ^ temp);
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      rcon_d  = rcon_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_GEN;
               i_d     = 6'd0;
               j_d     = 3'd0;
               rcon_d  = 8'h01;
            end
         end
         S_GEN: begin
            if (advance) begin
               i_d = i_q + 6'd1;
               j_d = (j_q == LAST_J) ? 3'd0 : j_q + 3'd1;
               if (i_q >= NK_I && j_q == 3'd0) rcon_d = xtime(rcon_q);
               if (i_q == LAST_I) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (accept && rk_round_q == LAST_R) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         i_q        <= 6'd0;
         j_q        <= 3'd0;
         rcon_q     <= 8'h01;
         asm_q      <= '0;
         rk_valid_q <= 1'b0;
         rk_data_q  <= '0;
         rk_round_q <= 4'd0;
         for (int k = 0; k < NK; k++) win_q[k] <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         rcon_q  <= rcon_d;
         if (load) begin
            for (int k = 0; k < NK; k++) win_q[k] <= key_in[KEY_BITS-1-32*k -: 32];
         end else if (advance) begin
            for (int k = 0; k < NK-1; k++) win_q[k] <= win_q[k+1];
            win_q[NK-1] <= word;
         end
         if (advance) begin
            case (i_q[1:0])
               2'd0: asm_q[95:64] <= word;
               2'd1: asm_q[63:32] <= word;
               2'd2: asm_q[31:0]  <= word;
               default: begin
                  rk_data_q  <= {asm_q, word};
                  rk_round_q <= i_q[5:2];
               end
            endcase
         end
         // A new key can only load when the slot is free, so load wins over the accept-clear.
         if (advance && i_q[1:0] == 2'd3) rk_valid_q <= 1'b1;
         else if (accept) rk_valid_q <= 1'b0;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign rk_valid = rk_valid_q;
   assign rk_data  = rk_data_q;
   assign rk_round = rk_round_q;

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Self-checking bench for aes_key_scheduler: three instances (AES-128/192/256) checked against
// a table-based reference key expansion through a scoreboard queue.
module tb_aes_key_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start [3];
   logic rk_ready [3];
   wire  busy_w [3];
   wire  vld_w [3];
   wire  [127:0] rkd_w [3];
   wire  [3:0]   rnd_w [3];
   logic [127:0] key128;
   logic [191:0] key192;
   logic [255:0] key256;

   always #5 clk = ~clk;

   aes_key_scheduler #(.KEY_BITS(128)) u_k128 (
      .clk(clk), .rst(rst), .start(start[0]), .key_in(key128), .busy(busy_w[0]),
      .rk_valid(vld_w[0]), .rk_ready(rk_ready[0]), .rk_data(rkd_w[0]), .rk_round(rnd_w[0]));
   aes_key_scheduler #(.KEY_BITS(192)) u_k192 (
      .clk(clk), .rst(rst), .start(start[1]), .key_in(key192), .busy(busy_w[1]),
      .rk_valid(vld_w[1]), .rk_ready(rk_ready[1]), .rk_data(rkd_w[1]), .rk_round(rnd_w[1]));
   aes_key_scheduler #(.KEY_BITS(256)) u_k256 (
      .clk(clk), .rst(rst), .start(start[2]), .key_in(key256), .busy(busy_w[2]),
      .rk_valid(vld_w[2]), .rk_ready(rk_ready[2]), .rk_data(rkd_w[2]), .rk_round(rnd_w[2]));

   typedef struct {
      logic [3:0]   rnd;
      logic [127:0] data;
   } exp_t;

   typedef struct {
      int           sel;
      logic [255:0] key;
      int           mode;
      int           rnd;
      logic [127:0] exp_rk;
   } vec_t;

   exp_t         sbq [$];
   vec_t         vt [8];
   logic [7:0]   sbox [256];
   logic [127:0] ref_rk [15];
   logic [127:0] cap [15];
   int           first_acc_cyc;
   int           n_cmp = 0;
   int           n_bad = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] x);
      return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
   endfunction

   task automatic ref_expand(input int nk, input logic [255:0] key);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      for (int k = 0; k < nk; k++) w[k] = key[255-32*k -: 32];
      rc = 8'h01;
      for (int k = nk; k < 4*(nk+7); k++) begin
         t = w[k-1];
         if (k % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = (rc << 1) ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (nk == 8 && k % nk == 4) begin
            t = subw(t);
         end
         w[k] = w[k-nk] ^ t;
      end
      for (int r = 0; r <= nk + 6; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // mode 0: ready high; 1: 7-cycle stall on r3; 2: stall plus random ready;
   // 3: start with another key during GEN; 5: reset while r5 is presented.
   task automatic run(input int sel, input logic [255:0] key, input int mode,
                      output int last_cyc, output int nacc);
      int   nk, nr, cyc, stall_left;
      exp_t e;
      nk = 4 + 2*sel;
      nr = nk + 6;
      ref_expand(nk, key);
      sbq.delete();
      for (int r = 0; r <= nr; r++) sbq.push_back('{4'(r), ref_rk[r]});
      for (int r = 0; r < 15; r++) cap[r] = '0;
      key128 = key[255 -: 128];
      key192 = key[255 -: 192];
      key256 = key;
      rk_ready[sel] = 1'b1;
      start[sel] = 1'b1;
      @(posedge clk); #1;
      start[sel] = 1'b0;
      cyc = 1; nacc = 0; last_cyc = -1; first_acc_cyc = -1;
      stall_left = (mode == 1 || mode == 2) ? 7 : 0;
      while (nacc <= nr && cyc < 400) begin
         if (mode == 5 && vld_w[sel] && rnd_w[sel] == 4'd5) begin
            rst = 1'b1;
            #1;
            chk("rst_rk_valid", 128'(vld_w[sel]), 128'd0);
            chk("rst_busy", 128'(busy_w[sel]), 128'd0);
            chk("rst_rk_data", rkd_w[sel], 128'd0);
            chk("rst_rk_round", 128'(rnd_w[sel]), 128'd0);
            rst = 1'b0;
            sbq.delete();
            break;
         end
         if (mode == 3 && cyc == 10) begin
            start[sel] = 1'b1;
            key128 = ~key[255 -: 128];
            key192 = ~key[255 -: 192];
            key256 = ~key;
         end
         if (mode == 3 && cyc == 11) start[sel] = 1'b0;
         if (stall_left > 0 && vld_w[sel] && rnd_w[sel] == 4'd3) begin
            rk_ready[sel] = 1'b0;
            stall_left--;
            chk("stall_hold_data", rkd_w[sel], ref_rk[3]);
         end else if (mode == 2) begin
            rk_ready[sel] = 1'($urandom_range(0, 1));
         end else begin
            rk_ready[sel] = 1'b1;
         end
         if (vld_w[sel] && rk_ready[sel]) begin
            if (sbq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL extra_key: got round %0d, want no further key", rnd_w[sel]);
            end else begin
               e = sbq.pop_front();
               chk("rk_round", 128'(rnd_w[sel]), 128'(e.rnd));
               chk("rk_data", rkd_w[sel], e.data);
            end
            cap[rnd_w[sel]] = rkd_w[sel];
            if (nacc == 0) first_acc_cyc = cyc;
            if (rnd_w[sel] == 4'(nr)) last_cyc = cyc;
            nacc++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (cyc >= 400) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout: got %0d keys after %0d cycles, want %0d", nacc, cyc, nr + 1);
      end
      if (mode != 5) begin
         chk("key_count", 128'(nacc), 128'(nr + 1));
         chk("sb_left", 128'(sbq.size()), 128'd0);
         chk("busy_after_last", 128'(busy_w[sel]), 128'd0);
         chk("valid_after_last", 128'(vld_w[sel]), 128'd0);
      end
   endtask

   initial begin
      logic [2047:0] sb_lit;
      logic [255:0]  k128, k192, k256, kalt;
      int            last, nacc, nr;
      sb_lit = {
         128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
         128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
         128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
         128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
         128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
         128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
         128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
         128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
      for (int n = 0; n < 256; n++) sbox[n] = sb_lit[2047-8*n -: 8];

      k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
      k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
      k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
      kalt = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

      vt[0] = '{0, k128, 0, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
      vt[1] = '{0, k128, 0, 1,  128'ha0fafe1788542cb123a339392a6c7605};
      vt[2] = '{0, k128, 0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vt[3] = '{1, k192, 0, 12, 128'he98ba06f448c773c8ecc720401002202};
      vt[4] = '{2, k256, 0, 1,  128'h1f352c073b6108d72d9810a30914dff4};
      vt[5] = '{2, k256, 0, 14, 128'hfe4890d1e6188d0b046df344706c631e};
      vt[6] = '{0, k128, 1, 3,  128'h3d80477d4716fe3e1e237e446d7a883b};
      vt[7] = '{0, k128, 2, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

      for (int s = 0; s < 3; s++) begin
         start[s]    = 1'b0;
         rk_ready[s] = 1'b0;
      end
      key128 = '0;
      key192 = '0;
      key256 = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         chk("reset_busy", 128'(busy_w[s]), 128'd0);
         chk("reset_valid", 128'(vld_w[s]), 128'd0);
         chk("reset_data", rkd_w[s], 128'd0);
         chk("reset_round", 128'(rnd_w[s]), 128'd0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      for (int v = 0; v < 8; v++) begin
         nr = 10 + 2*vt[v].sel;
         run(vt[v].sel, vt[v].key, vt[v].mode, last, nacc);
         chk($sformatf("vec%0d_round%0d", v, vt[v].rnd), cap[vt[v].rnd], vt[v].exp_rk);
         if (vt[v].mode == 0) begin
            chk("first_key_cycle", 128'(first_acc_cyc), 128'd5);
            chk("last_key_cycle", 128'(last), 128'(5 + 4*nr));
         end else if (vt[v].mode == 1) begin
            chk("stalled_last_cycle", 128'(last), 128'(5 + 4*nr + 7));
         end
      end

      run(0, k128, 3, last, nacc);
      chk("start_in_gen_r10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk("start_in_gen_last", 128'(last), 128'd45);
      run(0, kalt, 0, last, nacc);
      chk("back_to_back_r0", cap[0], kalt[255 -: 128]);
      chk("back_to_back_first", 128'(first_acc_cyc), 128'd5);

      run(0, k128, 5, last, nacc);
      chk("reset_busy_hold", 128'(busy_w[0]), 128'd0);
      run(0, k128, 0, last, nacc);
      chk("after_reset_r1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
      chk("after_reset_r10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk("after_reset_last", 128'(last), 128'd45);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
